// File: rtl/hist_stats_collector.sv
// Reduces a histogram dump to total/peak/peak-index/occupancy and emits it as a byte frame.
// Define HIST_STATS_CHECKSUM_EN to append an XOR checksum byte (B4) to each result frame.
module hist_stats_collector #(
  parameter int NUM_BINS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bin_valid,
  input  logic [3:0] bin_data,
  input  logic       bin_last,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {ACCUM, EMIT, RESYNC} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_BINS - 1);
`ifdef HIST_STATS_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  state_t     state_reg, state_next;
  logic [4:0] idx_reg;
  logic [8:0] sum_reg;
  logic [3:0] max_cnt_reg;
  logic [4:0] max_idx_reg;
  logic [5:0] nz_cnt_reg;
  logic       len_err_reg, drop_err_reg, pend_drop_reg, resync_reg;
  logic [2:0] byte_cnt_reg;
  logic [7:0] out_data_reg;
  logic       out_last_reg;

  logic       at_end, close_beat, accept, frame_done, drop_beat, enter_accum;
  logic [8:0] sum_next;
  logic [2:0] byte_num;
  logic [7:0] b1, b2, b3, byte_next;

  assign at_end      = (idx_reg == LAST_IDX);
  assign close_beat  = (state_reg == ACCUM) && bin_valid && (bin_last || at_end);
  assign accept      = out_valid && out_ready;
  assign frame_done  = accept && (byte_cnt_reg == LAST_BYTE);
  assign drop_beat   = bin_valid && (state_reg != ACCUM);
  assign enter_accum = (state_reg != ACCUM) && (state_next == ACCUM);
  assign sum_next    = sum_reg + {5'd0, bin_data};

  assign b1       = {sum_reg[8], 2'b00, max_idx_reg};
  assign b2       = {len_err_reg, drop_err_reg, nz_cnt_reg};
  assign b3       = {4'h0, max_cnt_reg};
  assign byte_num = byte_cnt_reg + 3'd1;

  always_comb begin
    byte_next = 8'h00;
    case (byte_num)
      3'd1: byte_next = b1;
      3'd2: byte_next = b2;
      3'd3: byte_next = b3;
`ifdef HIST_STATS_CHECKSUM_EN
      3'd4: byte_next = sum_reg[7:0] ^ b1 ^ b2 ^ b3;
`endif
      default: byte_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ACCUM;
    else     state_reg <= state_next;
  end

  // A beat dropped on the final-accept cycle decides where we land, like any other dropped beat.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:  if (close_beat) state_next = EMIT;
      EMIT: begin
        if (frame_done) begin
          if (bin_valid) state_next = bin_last ? ACCUM : RESYNC;
          else           state_next = resync_reg ? RESYNC : ACCUM;
        end
      end
      RESYNC: if (bin_valid && bin_last) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      sum_reg       <= '0;
      max_cnt_reg   <= '0;
      max_idx_reg   <= '0;
      nz_cnt_reg    <= '0;
      len_err_reg   <= 1'b0;
      drop_err_reg  <= 1'b0;
      pend_drop_reg <= 1'b0;
      resync_reg    <= 1'b0;
      byte_cnt_reg  <= '0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      if (state_reg == ACCUM && bin_valid) begin
        idx_reg <= idx_reg + 5'd1;
        sum_reg <= sum_next;
        if (bin_data > max_cnt_reg) begin
          max_cnt_reg <= bin_data;
          max_idx_reg <= idx_reg;
        end
        if (bin_data != 4'd0) nz_cnt_reg <= nz_cnt_reg + 6'd1;
        if (close_beat) begin
          len_err_reg  <= !(bin_last && at_end);
          resync_reg   <= at_end && !bin_last;
          byte_cnt_reg <= '0;
          out_data_reg <= sum_next[7:0];
          out_last_reg <= 1'b0;
        end
      end
      if (drop_beat) begin
        pend_drop_reg <= 1'b1;
        if (state_reg == EMIT) resync_reg <= !bin_last;
      end
      if (accept && !frame_done) begin
        byte_cnt_reg <= byte_num;
        out_data_reg <= byte_next;
        out_last_reg <= (byte_num == LAST_BYTE);
      end
      if (enter_accum) begin
        idx_reg       <= '0;
        sum_reg       <= '0;
        max_cnt_reg   <= '0;
        max_idx_reg   <= '0;
        nz_cnt_reg    <= '0;
        len_err_reg   <= 1'b0;
        drop_err_reg  <= pend_drop_reg || drop_beat;
        pend_drop_reg <= 1'b0;
      end
    end
  end

  assign out_valid = (state_reg == EMIT);
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != ACCUM);

endmodule
